// File: rtl/perf_reg_arbiter.sv
// Two-requester round-robin arbiter in front of a register bank.
// One bank transaction is in flight at a time. Every output is registered.
// Each requester has a saturating 16-bit grant counter.
module perf_reg_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic              bank_read,
    output logic              bank_write,
    output logic [ADDR_W-1:0] bank_address,
    output logic [DATA_W-1:0] bank_write_data,
    input  logic [DATA_W-1:0] bank_read_data,
    output logic [15:0]       m0_grant_cnt,
    output logic [15:0]       m1_grant_cnt,
    input  logic              cnt_clear
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // WAIT counts down from RD_LAT-2 to 0, giving RD_LAT-1 WAIT cycles.
    // RESP is the cycle in which bank_read_data is valid.
    localparam logic [1:0] WAIT_INIT = 2'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);

    state_t            state_reg;
    logic              owner_reg;      // last granted requester: 0 = m0, 1 = m1
    logic [1:0]        wait_cnt_reg;
    logic              m0_gnt_reg, m1_gnt_reg;
    logic              m0_rvalid_reg, m1_rvalid_reg;
    logic              bank_read_reg, bank_write_reg;
    logic [ADDR_W-1:0] bank_address_reg;
    logic [DATA_W-1:0] bank_write_data_reg;
    logic [DATA_W-1:0] m_rdata_reg;
    logic [15:0]       m0_cnt_reg, m1_cnt_reg;

    logic              win_m1;
    logic              grant_fire;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Pick the round-robin winner and mux its command fields.
    always_comb begin
        win_m1     = m1_req & (~m0_req | ~owner_reg);
        grant_fire = (state_reg == IDLE) && (m0_req || m1_req);
        sel_we     = win_m1 ? m1_we    : m0_we;
        sel_addr   = win_m1 ? m1_addr  : m0_addr;
        sel_wdata  = win_m1 ? m1_wdata : m0_wdata;
    end

    // Transaction FSM. Each output is set on the edge that enters the state where it is visible.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg           <= IDLE;
            owner_reg           <= 1'b1;
            wait_cnt_reg        <= '0;
            m0_gnt_reg          <= 1'b0;
            m1_gnt_reg          <= 1'b0;
            m0_rvalid_reg       <= 1'b0;
            m1_rvalid_reg       <= 1'b0;
            bank_read_reg       <= 1'b0;
            bank_write_reg      <= 1'b0;
            bank_address_reg    <= '0;
            bank_write_data_reg <= '0;
            m_rdata_reg         <= '0;
        end else begin
            m0_gnt_reg     <= 1'b0;
            m1_gnt_reg     <= 1'b0;
            m0_rvalid_reg  <= 1'b0;
            m1_rvalid_reg  <= 1'b0;
            bank_read_reg  <= 1'b0;
            bank_write_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        owner_reg           <= win_m1;
                        m0_gnt_reg          <= ~win_m1;
                        m1_gnt_reg          <= win_m1;
                        bank_write_reg      <= sel_we;
                        bank_read_reg       <= ~sel_we;
                        bank_address_reg    <= sel_addr;
                        bank_write_data_reg <= sel_wdata;
                        state_reg           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bank_write_reg) begin
                        state_reg <= IDLE;
                    end else if (RD_LAT == 1) begin
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= WAIT_INIT;
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_reg == 2'd0) begin
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 2'd1;
                    end
                end
                RESP: begin
                    m_rdata_reg   <= bank_read_data;
                    m0_rvalid_reg <= ~owner_reg;
                    m1_rvalid_reg <= owner_reg;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Saturating grant counters. Clear has priority over a coincident grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m0_cnt_reg <= '0;
            m1_cnt_reg <= '0;
        end else if (cnt_clear) begin
            m0_cnt_reg <= '0;
            m1_cnt_reg <= '0;
        end else begin
            m0_cnt_reg <= (grant_fire && !win_m1 && m0_cnt_reg != 16'hFFFF) ? m0_cnt_reg + 16'd1 : m0_cnt_reg;
            m1_cnt_reg <= (grant_fire &&  win_m1 && m1_cnt_reg != 16'hFFFF) ? m1_cnt_reg + 16'd1 : m1_cnt_reg;
        end
    end

    assign m0_gnt          = m0_gnt_reg;
    assign m1_gnt          = m1_gnt_reg;
    assign m0_rvalid       = m0_rvalid_reg;
    assign m1_rvalid       = m1_rvalid_reg;
    assign m_rdata         = m_rdata_reg;
    assign bank_read       = bank_read_reg;
    assign bank_write      = bank_write_reg;
    assign bank_address    = bank_address_reg;
    assign bank_write_data = bank_write_data_reg;
    assign m0_grant_cnt    = m0_cnt_reg;
    assign m1_grant_cnt    = m1_cnt_reg;

endmodule

// File: tb/tb_perf_reg_arbiter.sv
// Directed bench for perf_reg_arbiter.
// Instance dut uses RD_LAT=1 and instance dut3 uses RD_LAT=3.
// A small bank model sits behind each instance.
module tb_perf_reg_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- RD_LAT = 1 instance ----------------
    logic        m0_req, m0_we, m1_req, m1_we, cnt_clear;
    logic [8:0]  m0_addr, m1_addr, bank_address;
    logic [31:0] m0_wdata, m1_wdata, m_rdata, bank_write_data, bank_read_data;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bank_read, bank_write;
    logic [15:0] m0_grant_cnt, m1_grant_cnt;

    perf_reg_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m_rdata(m_rdata), .bank_read(bank_read), .bank_write(bank_write),
        .bank_address(bank_address), .bank_write_data(bank_write_data),
        .bank_read_data(bank_read_data), .m0_grant_cnt(m0_grant_cnt),
        .m1_grant_cnt(m1_grant_cnt), .cnt_clear(cnt_clear)
    );

    // Bank model: storage array with one-cycle read latency.
    // Read data is DEADBEEF in any cycle that is not a read return.
    logic [31:0] mem [0:511];
    logic [31:0] rd_q = 32'hDEADBEEF;
    always @(posedge clk) begin
        if (bank_write) mem[bank_address] <= bank_write_data;
        rd_q <= bank_read ? mem[bank_address] : 32'hDEADBEEF;
    end
    assign bank_read_data = rd_q;

    // ---------------- RD_LAT = 3 instance ----------------
    logic        x_m0_req, x_m0_we, x_m1_req, x_m1_we, x_cnt_clear;
    logic [8:0]  x_m0_addr, x_m1_addr, x_bank_address;
    logic [31:0] x_m0_wdata, x_m1_wdata, x_m_rdata, x_bank_write_data, x_bank_read_data;
    logic        x_m0_gnt, x_m1_gnt, x_m0_rvalid, x_m1_rvalid, x_bank_read, x_bank_write;
    logic [15:0] x_m0_grant_cnt, x_m1_grant_cnt;

    perf_reg_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .m0_req(x_m0_req), .m0_we(x_m0_we), .m0_addr(x_m0_addr), .m0_wdata(x_m0_wdata),
        .m1_req(x_m1_req), .m1_we(x_m1_we), .m1_addr(x_m1_addr), .m1_wdata(x_m1_wdata),
        .m0_gnt(x_m0_gnt), .m1_gnt(x_m1_gnt), .m0_rvalid(x_m0_rvalid), .m1_rvalid(x_m1_rvalid),
        .m_rdata(x_m_rdata), .bank_read(x_bank_read), .bank_write(x_bank_write),
        .bank_address(x_bank_address), .bank_write_data(x_bank_write_data),
        .bank_read_data(x_bank_read_data), .m0_grant_cnt(x_m0_grant_cnt),
        .m1_grant_cnt(x_m1_grant_cnt), .cnt_clear(x_cnt_clear)
    );

    // Three-stage bank model: a read of address A returns C0DE0000 ^ A exactly 3 cycles later.
    logic [31:0] x_p1 = 32'hDEADBEEF, x_p2 = 32'hDEADBEEF, x_p3 = 32'hDEADBEEF;
    always @(posedge clk) begin
        x_p1 <= x_bank_read ? ({23'h0, x_bank_address} ^ 32'hC0DE0000) : 32'hDEADBEEF;
        x_p2 <= x_p1;
        x_p3 <= x_p2;
    end
    assign x_bank_read_data = x_p3;

    // ---------------- checking ----------------
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // All stimulus changes and all samples happen on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // m0 write that is held until its grant, followed by the return to IDLE.
    task automatic m0_write(input logic [8:0] a, input logic [31:0] d);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = a; m0_wdata = d;
        tick();
        m0_req = 1'b0;
        tick();
    endtask

    logic seen;

    initial begin
        reset_n  = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; cnt_clear = 0;
        x_m0_req = 0; x_m0_we = 0; x_m0_addr = '0; x_m0_wdata = '0;
        x_m1_req = 0; x_m1_we = 0; x_m1_addr = '0; x_m1_wdata = '0; x_cnt_clear = 0;
        tick(); tick(); tick();

        // Values while reset is held low.
        chk("rst_gnt",     32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}), 32'd0);
        chk("rst_strobes", 32'({bank_read, bank_write}), 32'd0);
        chk("rst_addr",    32'(bank_address), 32'd0);
        chk("rst_wdata",   bank_write_data, 32'd0);
        chk("rst_rdata",   m_rdata, 32'd0);
        chk("rst_cnts",    {m0_grant_cnt, m1_grant_cnt}, 32'd0);
        reset_n = 1'b1;
        tick();

        // m0 writes AAAAAAAA to address 0. Grant and bank write appear in the same single cycle.
        m0_req = 1; m0_we = 1; m0_addr = 9'h000; m0_wdata = 32'hAAAAAAAA;
        tick();
        chk("wr_gnt",      32'({m0_gnt, m1_gnt}), 32'b10);
        chk("wr_strobes",  32'({bank_write, bank_read}), 32'b10);
        chk("wr_addr",     32'(bank_address), 32'h000);
        chk("wr_data",     bank_write_data, 32'hAAAAAAAA);
        chk("wr_cnt0",     32'(m0_grant_cnt), 32'd1);
        m0_req = 0;
        tick();
        chk("wr_done",     32'({m0_gnt, bank_write}), 32'd0);

        // m1 reads address 0. rvalid is expected 2 cycles after gnt.
        m1_req = 1; m1_we = 0; m1_addr = 9'h000;
        tick();
        chk("rd_gnt",      32'({m0_gnt, m1_gnt}), 32'b01);
        chk("rd_strobes",  32'({bank_write, bank_read}), 32'b01);
        m1_req = 0;
        tick();
        chk("rd_rv_early", 32'({m0_rvalid, m1_rvalid}), 32'd0);
        tick();
        chk("rd_rvalid",   32'({m0_rvalid, m1_rvalid}), 32'b01);
        chk("rd_rdata",    m_rdata, 32'hAAAAAAAA);
        tick();
        chk("rd_rv_end",   32'({m0_rvalid, m1_rvalid}), 32'd0);
        chk("rd_hold",     m_rdata, 32'hAAAAAAAA);
        chk("rd_cnt1",     32'(m1_grant_cnt), 32'd1);

        // Tie from reset: m0 is granted first. m0 then raises a new request while m1 still waits.
        // That repeat tie must go to m1.
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 9'h002; m0_wdata = 32'hBBBBBBBB;
        m1_req = 1; m1_we = 1; m1_addr = 9'h004; m1_wdata = 32'hCCCCCCCC;
        tick();
        chk("tie1_gnt",    32'({m0_gnt, m1_gnt}), 32'b10);
        chk("tie1_addr",   32'(bank_address), 32'h002);
        chk("tie1_data",   bank_write_data, 32'hBBBBBBBB);
        m0_addr = 9'h006; m0_wdata = 32'hDDDDDDDD;
        tick();
        chk("tie_gap",     32'({m0_gnt, m1_gnt}), 32'd0);
        tick();
        chk("tie2_gnt",    32'({m0_gnt, m1_gnt}), 32'b01);
        chk("tie2_addr",   32'(bank_address), 32'h004);
        chk("tie2_data",   bank_write_data, 32'hCCCCCCCC);
        m1_req = 0;
        tick();
        tick();
        chk("tie3_gnt",    32'({m0_gnt, m1_gnt}), 32'b10);
        chk("tie3_data",   bank_write_data, 32'hDDDDDDDD);
        m0_req = 0;
        tick();
        chk("tie_cnts",    {m0_grant_cnt, m1_grant_cnt}, {16'd2, 16'd1});

        // Saturation. The counter is preloaded to FFFE, then two more grants must stop it at FFFF.
        force dut.m0_cnt_reg = 16'hFFFE;
        tick();
        release dut.m0_cnt_reg;
        tick();
        chk("sat_preload", 32'(m0_grant_cnt), 32'h0000FFFE);
        m0_write(9'h010, 32'h11111111);
        chk("sat_reach",   32'(m0_grant_cnt), 32'h0000FFFF);
        m0_write(9'h011, 32'h22222222);
        chk("sat_hold",    32'(m0_grant_cnt), 32'h0000FFFF);

        // cnt_clear on the same edge as a grant: the clear wins.
        m0_req = 1; m0_we = 1; m0_addr = 9'h012; m0_wdata = 32'h33333333; cnt_clear = 1;
        tick();
        chk("clr_gnt",     32'(m0_gnt), 32'd1);
        chk("clr_cnts",    {m0_grant_cnt, m1_grant_cnt}, 32'd0);
        m0_req = 0; cnt_clear = 0;
        tick();

        // RD_LAT=3: rvalid follows 4 cycles after the ISSUE cycle.
        x_m0_req = 1; x_m0_we = 0; x_m0_addr = 9'h003;
        tick();
        chk("l3_gnt",      32'({x_m0_gnt, x_bank_read}), 32'b11);
        x_m0_req = 0;
        tick(); tick(); tick();
        chk("l3_rv_early", 32'({x_m0_rvalid, x_m1_rvalid}), 32'd0);
        tick();
        chk("l3_rvalid",   32'({x_m0_rvalid, x_m1_rvalid}), 32'b10);
        chk("l3_rdata",    x_m_rdata, 32'hC0DE0003);
        tick();

        // Reset in WAIT aborts the read. Afterwards there is no rvalid and the reset values are back.
        x_m1_req = 1; x_m1_we = 0; x_m1_addr = 9'h007;
        tick();
        chk("ab_gnt",      32'({x_m1_gnt, x_bank_read}), 32'b11);
        x_m1_req = 0;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("ab_addr",     32'(x_bank_address), 32'd0);
        chk("ab_rdata",    x_m_rdata, 32'd0);
        chk("ab_cnts",     {x_m0_grant_cnt, x_m1_grant_cnt}, 32'd0);
        chk("ab_strobes",  32'({x_bank_read, x_bank_write, x_m0_gnt, x_m1_gnt}), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | x_m0_rvalid | x_m1_rvalid;
            tick();
        end
        chk("ab_no_rvalid", 32'(seen), 32'd0);
        x_m0_req = 1; x_m0_we = 1; x_m0_addr = 9'h001; x_m0_wdata = 32'h44444444;
        tick();
        chk("ab_idle_gnt", 32'({x_m0_gnt, x_bank_write}), 32'b11);
        x_m0_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
